// File: rtl/counter_arbiter.sv
// Four-requester arbiter lending one shared 8-bit run counter.
// Each winner owns the counter for its latched duration, then pulses DONE.
module counter_arbiter #(
    parameter bit RR = 1'b1
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic [3:0] REQ,
    input  logic [7:0] D0,
    input  logic [7:0] D1,
    input  logic [7:0] D2,
    input  logic [7:0] D3,
    output logic [3:0] GNT,
    output logic [3:0] DONE,
    output logic [1:0] OWNER,
    output logic       BUSY,
    output logic [7:0] C
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [7:0] dur;
    logic [7:0] dur_n;
    logic [7:0] c_n;
    logic [7:0] c_inc;
    logic [7:0] dw;
    logic [3:0] gnt_n;
    logic [3:0] done_n;
    logic [1:0] owner_n;
    logic [1:0] win;
    logic       busy_n;
    logic       any_req;

    assign any_req = |REQ;
    assign c_inc   = C + 8'd1;

    // Scan in reverse so the earliest candidate in search order wins.
    always_comb begin
        win = 2'd0;
        if (RR) begin
            for (int i = 4; i >= 1; i--) begin
                if (REQ[OWNER + 2'(i)]) begin
                    win = OWNER + 2'(i);
                end
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (REQ[i]) begin
                    win = 2'(i);
                end
            end
        end
    end

    always_comb begin
        dw = D0;
        case (win)
            2'd0:    dw = D0;
            2'd1:    dw = D1;
            2'd2:    dw = D2;
            default: dw = D3;
        endcase
    end

    always_comb begin
        state_n = state;
        gnt_n   = GNT;
        done_n  = 4'd0;
        owner_n = OWNER;
        c_n     = C;
        dur_n   = dur;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    owner_n = win;
                    c_n     = 8'd0;
                    dur_n   = dw;
                    if (dw != 8'd0) begin
                        state_n = RUN;
                        gnt_n   = 4'b0001 << win;
                    end else begin
                        state_n = FIN;
                        done_n  = 4'b0001 << win;
                    end
                end
            end
            RUN: begin
                if (REQ[OWNER]) begin
                    c_n = c_inc;
                    if (c_inc == dur) begin
                        state_n = FIN;
                        gnt_n   = 4'd0;
                        done_n  = 4'b0001 << OWNER;
                    end
                end else begin
                    // Owner withdrew: release silently, counter frozen.
                    state_n = IDLE;
                    gnt_n   = 4'd0;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'd0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state <= IDLE;
            GNT   <= 4'd0;
            DONE  <= 4'd0;
            C     <= 8'd0;
            dur   <= 8'd0;
            OWNER <= 2'd3;
            BUSY  <= 1'b0;
        end else begin
            state <= state_n;
            GNT   <= gnt_n;
            DONE  <= done_n;
            C     <= c_n;
            dur   <= dur_n;
            OWNER <= owner_n;
            BUSY  <= busy_n;
        end
    end

    a_gnt_onehot: assert property (@(posedge CLK) disable iff (RES)
        $onehot0(GNT));
    a_done_onehot: assert property (@(posedge CLK) disable iff (RES)
        $onehot0(DONE));
    a_gnt_done_excl: assert property (@(posedge CLK) disable iff (RES)
        !((GNT != 4'd0) && (DONE != 4'd0)));
    a_busy_state: assert property (@(posedge CLK) disable iff (RES)
        BUSY == (state != IDLE));

endmodule
